// File: rtl/msg_policer_pkg.sv
// Shared types and helpers for the message drop policer.
// Contents:
//   state_e      - per-message tracking state (idle / passing / dropping)
//   *_DEF        - default widths for bucket, refill period and statistics
//   sat_add_sub  - clamped base + add - sub, bounded to [0, ceil]
package msg_policer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int unsigned TOKEN_W_DEF  = 16;
  localparam int unsigned PERIOD_W_DEF = 16;
  localparam int unsigned CNT_W_DEF    = 32;

  // Operands are zero-extended to 64 bits by the caller, so base + add
  // cannot overflow for any width this block is built with, and an
  // oversubscribed subtraction floors at zero instead of wrapping.
  function automatic logic [63:0] sat_add_sub(input logic [63:0] base,
                                              input logic [63:0] add,
                                              input logic [63:0] sub,
                                              input logic [63:0] ceil);
    logic [63:0] sum;
    logic [63:0] res;
    sum = base + add;
    if (sum < sub) begin
      res = 64'd0;
    end else if ((sum - sub) > ceil) begin
      res = ceil;
    end else begin
      res = sum - sub;
    end
    return res;
  endfunction

endpackage

// File: rtl/msg_drop_policer_token_bucket.sv
// Token bucket: periodic refill plus per-beat charge, clamped to capacity.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   enable          - 0 pins the level to cfg_bucket_max every cycle
//   cfg_rate        - tokens added on each refill
//   cfg_period      - cycles between refills (0 behaves as 1)
//   cfg_bucket_max  - bucket capacity
//   charge          - remove one token this cycle
//   level           - registered token level
//   level_next      - level that will be loaded on the coming edge
module token_bucket
  import msg_policer_pkg::*;
#(
  parameter int unsigned TOKEN_W  = TOKEN_W_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [TOKEN_W-1:0]  cfg_rate,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [TOKEN_W-1:0]  cfg_bucket_max,
  input  logic                charge,
  output logic [TOKEN_W-1:0]  level,
  output logic [TOKEN_W-1:0]  level_next
);

  logic [PERIOD_W-1:0] r_period_cnt;
  logic [TOKEN_W-1:0]  r_level;
  logic [PERIOD_W-1:0] w_period_last;
  logic                w_terminal;
  logic [TOKEN_W-1:0]  w_refill;
  logic [TOKEN_W-1:0]  w_level_next;

  // Refill timing and next bucket level.
  always_comb begin
    w_period_last = {PERIOD_W{1'b0}};
    w_terminal    = 1'b0;
    w_refill      = {TOKEN_W{1'b0}};
    w_level_next  = r_level;
    if (cfg_period == {PERIOD_W{1'b0}}) begin
      w_period_last = {PERIOD_W{1'b0}};
    end else begin
      w_period_last = cfg_period - PERIOD_W'(1);
    end
    // >= rather than == so shrinking cfg_period mid-count wraps at once.
    w_terminal = (r_period_cnt >= w_period_last);
    if (w_terminal) begin
      w_refill = cfg_rate;
    end else begin
      w_refill = {TOKEN_W{1'b0}};
    end
    if (!enable) begin
      w_level_next = cfg_bucket_max;
    end else begin
      w_level_next = TOKEN_W'(sat_add_sub(64'(r_level), 64'(w_refill),
                                          64'(charge), 64'(cfg_bucket_max)));
    end
  end

  // Period counter and level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_cnt <= {PERIOD_W{1'b0}};
      r_level      <= {TOKEN_W{1'b0}};
    end else begin
      r_period_cnt <= w_terminal ? {PERIOD_W{1'b0}} : (r_period_cnt + PERIOD_W'(1));
      r_level      <= w_level_next;
    end
  end

  assign level      = r_level;
  assign level_next = w_level_next;

endmodule

// File: rtl/msg_drop_policer.sv
// Token-bucket policer producing the per-message drop decision for a
// message dropper on the same Avalon-ST stream, by watching its handshake.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   enable                - 0 passes everything and keeps the bucket full
//   cfg_rate/cfg_period   - refill amount and interval
//   cfg_bucket_max        - bucket capacity
//   cfg_thresh            - minimum level to admit a message
//   cnt_clr               - clear statistics and protocol_err
//   mon_valid/ready/sop/eop - monitored stream handshake
//   drop                  - registered drop request (sampled by dropper on sop)
//   bucket_level          - current token level
//   pass_cnt/drop_cnt     - saturating message statistics
//   protocol_err          - sticky framing error
module msg_drop_policer
  import msg_policer_pkg::*;
#(
  parameter int unsigned TOKEN_W  = TOKEN_W_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [TOKEN_W-1:0]  cfg_rate,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [TOKEN_W-1:0]  cfg_bucket_max,
  input  logic [TOKEN_W-1:0]  cfg_thresh,
  input  logic                cnt_clr,
  input  logic                mon_valid,
  input  logic                mon_ready,
  input  logic                mon_sop,
  input  logic                mon_eop,
  output logic                drop,
  output logic [TOKEN_W-1:0]  bucket_level,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                protocol_err
);

  state_e             r_state;
  logic               r_drop;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_protocol_err;

  state_e             w_state_next;
  logic               w_hs;
  logic               w_charge;
  logic               w_cls_pass;
  logic               w_cls_drop;
  logic               w_err_set;
  logic [TOKEN_W-1:0] w_level_next;

  token_bucket #(
    .TOKEN_W  (TOKEN_W),
    .PERIOD_W (PERIOD_W)
  ) u_bucket (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .cfg_rate       (cfg_rate),
    .cfg_period     (cfg_period),
    .cfg_bucket_max (cfg_bucket_max),
    .charge         (w_charge),
    .level          (bucket_level),
    .level_next     (w_level_next)
  );

  assign w_hs = mon_valid & mon_ready;

  // Message framing FSM: classify on sop, charge beats of passed messages.
  always_comb begin
    w_state_next = r_state;
    w_charge     = 1'b0;
    w_cls_pass   = 1'b0;
    w_cls_drop   = 1'b0;
    w_err_set    = 1'b0;
    if (w_hs) begin
      if (mon_sop) begin
        // A sop inside a message is an error, but still starts a new message.
        w_err_set  = (r_state != ST_IDLE);
        w_cls_pass = ~r_drop;
        w_cls_drop = r_drop;
        w_charge   = ~r_drop;
        if (mon_eop) begin
          w_state_next = ST_IDLE;
        end else if (r_drop) begin
          w_state_next = ST_DROP;
        end else begin
          w_state_next = ST_PASS;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_err_set = 1'b1;
          end
          ST_PASS: begin
            w_charge     = 1'b1;
            w_state_next = mon_eop ? ST_IDLE : ST_PASS;
          end
          ST_DROP: begin
            w_state_next = mon_eop ? ST_IDLE : ST_DROP;
          end
          default: begin
            w_state_next = ST_IDLE;
          end
        endcase
      end
    end else begin
      w_state_next = r_state;
    end
  end

  // State, drop decision, statistics and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_drop         <= 1'b0;
      r_pass_cnt     <= {CNT_W{1'b0}};
      r_drop_cnt     <= {CNT_W{1'b0}};
      r_protocol_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= enable & (w_level_next < cfg_thresh);
      if (cnt_clr) begin
        r_pass_cnt     <= {CNT_W{1'b0}};
        r_drop_cnt     <= {CNT_W{1'b0}};
        r_protocol_err <= 1'b0;
      end else begin
        if (w_cls_pass) begin
          r_pass_cnt <= CNT_W'(sat_add_sub(64'(r_pass_cnt), 64'd1, 64'd0,
                                           64'({CNT_W{1'b1}})));
        end
        if (w_cls_drop) begin
          r_drop_cnt <= CNT_W'(sat_add_sub(64'(r_drop_cnt), 64'd1, 64'd0,
                                           64'({CNT_W{1'b1}})));
        end
        if (w_err_set) begin
          r_protocol_err <= 1'b1;
        end
      end
    end
  end

  assign drop         = r_drop;
  assign pass_cnt     = r_pass_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign protocol_err = r_protocol_err;

endmodule

// File: doc/msg_drop_policer.md
Name: msg_drop_policer

Overview:
- Token-bucket policer that generates the per-message `drop` decision for the message dropper on the same Avalon-ST stream.
- Passively monitors the dropper's input handshake (valid/ready/sop/eop) and charges one token per accepted beat of each passed message.
- Asserts `drop` when the bucket is below a configurable threshold.
- Keeps pass/drop statistics and flags framing errors. Sits alongside the dropper in the ingress path; configured from the CSR block.

Parameters:
- TOKEN_W, 16, width of bucket level, rate, max and threshold.
- PERIOD_W, 16, width of refill-period counter.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  policing enable; 0 = pass everything
- cfg_rate  input  TOKEN_W  tokens added per refill
- cfg_period  input  PERIOD_W  cycles between refills; 0 treated as 1
- cfg_bucket_max  input  TOKEN_W  bucket capacity
- cfg_thresh  input  TOKEN_W  minimum level to admit a message
- cnt_clr  input  1  synchronous clear of statistics and protocol_err
- mon_valid  input  1  monitored stream valid
- mon_ready  input  1  monitored stream ready (dropper's msg_in.ready)
- mon_sop  input  1  monitored start of packet
- mon_eop  input  1  monitored end of packet
- drop  output  1  drop request to the dropper
- bucket_level  output  TOKEN_W  current token level
- pass_cnt  output  CNT_W  messages passed
- drop_cnt  output  CNT_W  messages dropped
- protocol_err  output  1  sticky framing error

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: bucket_level=0, drop=0, pass_cnt=0, drop_cnt=0, protocol_err=0, period counter=0, FSM=IDLE.
- Beat handshake: hs = mon_valid & mon_ready.
- drop is registered: drop <= enable & (level_next < cfg_thresh). The decision applied to a message is the value of drop during its sop handshake cycle. This matches the dropper, which samples drop combinationally on the sop beat.
- FSM states: IDLE, PASS, DROP.
  - IDLE, hs&sop&!eop → PASS if drop==0, else DROP.
  - PASS/DROP, hs&eop → IDLE.
  - hs&sop&eop from any state: single-beat message, classified on that beat, FSM → IDLE.
- Framing errors:
  - hs&sop while in PASS/DROP: set protocol_err, classify as a new message, restart.
  - hs&!sop in IDLE: set protocol_err; beat not charged, not counted.
- Charge: 1 token for each hs beat belonging to a passed message, including its sop beat. Beats of dropped messages are not charged.
- Refill: period counter counts 0..max(cfg_period,1)-1. On the terminal count, add cfg_rate and wrap the counter to 0.
- Level update, same cycle:
  - level_next = clamp(level + refill − charge, 0, cfg_bucket_max).
  - Arithmetic is at TOKEN_W+2 bits, so refill and charge in the same cycle net correctly.
  - Level saturates at 0 and never wraps.
  - Lowering cfg_bucket_max below the current level clamps it on the next cycle.
- enable=0:
  - level forced to cfg_bucket_max each cycle; drop=0; the FSM still tracks framing.
  - An enable change mid-message does not alter that message's classification.
- Counters: pass_cnt/drop_cnt increment on each sop handshake per classification. They saturate at all-ones. cnt_clr has priority over a same-cycle increment.
- Reset mid-message: everything returns to reset values. Following non-sop beats raise protocol_err.

Decomposition:
- Package msg_policer_pkg: state enum typedef (IDLE/PASS/DROP), default width localparams, and a saturating add/sub function.
- Sub-module token_bucket: owns the period counter, the refill and the clamped level. Inputs are charge and enable; output is level.
- The FSM, counters and drop register stay in msg_drop_policer.

Test Plan:
1. enable=0, 3 messages of 4 beats with mon_ready=1 → drop stays 0, pass_cnt=3, drop_cnt=0, bucket_level=cfg_bucket_max.
2. enable=1, max=10, thresh=4, rate=0; level 10 (loaded via enable=0 then 1); two 4-beat messages → first passes (level 6), second passes (level 2); third message dropped; drop_cnt=1, level stays 2.
3. rate=3, period=5, no traffic from level 0 → level 3 at cycle 5, 6 at cycle 10; with max=7, level 7 at cycle 15 (saturates).
4. Refill terminal count coincides with a passed beat at level 1, rate 2 → level 2 next cycle; a 6-beat passed message starting at level 2 with rate 0 → level ends at 0, no wrap.
5. sop, data, sop (no eop) → protocol_err=1, second sop counted as a new message. Then cnt_clr → counters 0, protocol_err 0.
6. mon_valid=1, mon_ready=0 stall on sop for 3 cycles → no classification until the ready cycle; single-beat sop&eop → FSM stays IDLE, charged 1 if passed.
